// File: rtl/conv3x3_scanner.sv
// conv3x3_scanner: walks a 3x3 kernel across the image ROM (no padding,
// stride 1). For each output it accumulates nine pixel*coefficient products,
// one per cycle, then offers the sum downstream on a valid/ready handshake.
module conv3x3_scanner #(
    parameter int IMG_ROWS = 10,
    parameter int IMG_COLS = 12,
    parameter int K        = 3,
    parameter int DATA_W   = 4,
    parameter int ACC_W    = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [K*K*DATA_W-1:0] kernel_flat,
    output logic [3:0]            img_x,
    output logic [3:0]            img_y,
    input  logic [DATA_W-1:0]     pix_in,
    output logic [ACC_W-1:0]      result,
    output logic [2:0]            result_row,
    output logic [3:0]            result_col,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  busy,
    output logic                  done
);

    // Last output position and last kernel tap of one window.
    localparam logic [2:0] ROW_LAST = 3'(IMG_ROWS - K);
    localparam logic [3:0] COL_LAST = 4'(IMG_COLS - K);
    localparam logic [3:0] K_LAST   = 4'(K * K - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              row_q, row_d;
    logic [3:0]              col_q, col_d;
    logic [3:0]              k_q, k_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [K*K*DATA_W-1:0]   kern_q, kern_d;
    logic [ACC_W-1:0]        result_q, result_d;
    logic                    valid_q, valid_d;

    logic [1:0]              k_row, k_col;
    logic [DATA_W-1:0]       coef;
    logic [2*DATA_W-1:0]     prod;
    logic [ACC_W-1:0]        mac_sum;

    // Split the tap index into its kernel row (k/3) and column (k%3).
    always_comb begin
        k_row = 2'd2;
        k_col = 2'd2;
        case (k_q)
            4'd0: begin k_row = 2'd0; k_col = 2'd0; end
            4'd1: begin k_row = 2'd0; k_col = 2'd1; end
            4'd2: begin k_row = 2'd0; k_col = 2'd2; end
            4'd3: begin k_row = 2'd1; k_col = 2'd0; end
            4'd4: begin k_row = 2'd1; k_col = 2'd1; end
            4'd5: begin k_row = 2'd1; k_col = 2'd2; end
            4'd6: begin k_row = 2'd2; k_col = 2'd0; end
            4'd7: begin k_row = 2'd2; k_col = 2'd1; end
            default: begin k_row = 2'd2; k_col = 2'd2; end
        endcase
    end

    // Product is at most 15*15 = 225, zero-extended into the accumulator.
    assign coef    = kern_q[{k_q, 2'b00} +: DATA_W];
    assign prod    = pix_in * coef;
    assign mac_sum = acc_q + {{(ACC_W - 2*DATA_W){1'b0}}, prod};

    // ROM address comes from registered counters; parked at 0 outside MAC.
    assign img_x = (state_q == S_MAC) ? ({1'b0, row_q} + {2'b00, k_row}) : 4'd0;
    assign img_y = (state_q == S_MAC) ? (col_q + {2'b00, k_col}) : 4'd0;

    assign result       = result_q;
    assign result_row   = row_q;
    assign result_col   = col_q;
    assign result_valid = valid_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);

    // Next-state logic for the scan FSM and its datapath registers.
    always_comb begin
        // NOTE: every _d starts as its _q so no path leaves one unassigned (no latches).
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        k_d      = k_q;
        acc_d    = acc_q;
        kern_d   = kern_q;
        result_d = result_q;
        valid_d  = valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    kern_d  = kernel_flat;
                    acc_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    k_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = mac_sum;
                if (k_q == K_LAST) begin
                    result_d = mac_sum;
                    valid_d  = 1'b1;
                    state_d  = S_EMIT;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            S_EMIT: begin
                if (result_ready) begin
                    valid_d = 1'b0;
                    acc_d   = '0;
                    k_d     = '0;
                    if (row_q == ROW_LAST && col_q == COL_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + 3'd1;
                        end else begin
                            col_d = col_q + 4'd1;
                        end
                        state_d = S_MAC;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            kern_q   <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            kern_q   <= kern_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

endmodule
